// File: rtl/axi_router_pkg.sv
// Shared definitions for the HP AXI burst router: response codes, FSM state
// encodings and a width helper.
package axi_router_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2,
        R_ERR  = 2'd3
    } rd_state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hp_axi_router_rd.sv
// Read half of the HP AXI router: one outstanding AR burst, routed to the
// selected channel or answered locally with DECERR beats on a decode miss.
module hp_axi_router_rd
    import axi_router_pkg::*;
#(
    parameter int ADDR_WIDTH    = 48,
    parameter int CH_ADDR_WIDTH = 34,
    parameter int DATA_WIDTH    = 128,
    parameter int NUM_CH        = 2,
    parameter int SEL_LSB       = 34,
    parameter int SEL_W         = 1
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [ADDR_WIDTH-1:0]             s_araddr,
    input  logic [7:0]                        s_arlen,
    input  logic [2:0]                        s_arsize,
    input  logic [1:0]                        s_arburst,
    input  logic                              s_arvalid,
    output logic                              s_arready,
    input  logic                              s_rready,
    output logic                              s_rvalid,
    output logic [DATA_WIDTH-1:0]             s_rdata,
    output logic [1:0]                        s_rresp,
    output logic                              s_rlast,
    output logic [NUM_CH*CH_ADDR_WIDTH-1:0]   m_araddr,
    output logic [NUM_CH*8-1:0]               m_arlen,
    output logic [NUM_CH*3-1:0]               m_arsize,
    output logic [NUM_CH*2-1:0]               m_arburst,
    output logic [NUM_CH-1:0]                 m_arvalid,
    input  logic [NUM_CH-1:0]                 m_arready,
    output logic [NUM_CH-1:0]                 m_rready,
    input  logic [NUM_CH-1:0]                 m_rvalid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]      m_rdata,
    input  logic [NUM_CH*2-1:0]               m_rresp,
    input  logic [NUM_CH-1:0]                 m_rlast
);

    localparam logic [SEL_W:0] CH_COUNT = (SEL_W+1)'(NUM_CH);

    rd_state_t                  rd_state;
    rd_state_t                  rd_next;
    logic [CH_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                 ar_len;
    logic [2:0]                 ar_size;
    logic [1:0]                 ar_burst;
    logic [SEL_W-1:0]           ar_sel;
    logic [7:0]                 beat_cnt;
    logic [SEL_W-1:0]           ar_sel_in;
    logic                       ar_hit_in;
    logic                       unused_ar_bits;

    assign ar_sel_in      = s_araddr[SEL_LSB +: SEL_W];
    assign ar_hit_in      = ({1'b0, ar_sel_in} < CH_COUNT);
    assign unused_ar_bits = &{1'b0, s_araddr};

    assign m_araddr  = {NUM_CH{ar_addr}};
    assign m_arlen   = {NUM_CH{ar_len}};
    assign m_arsize  = {NUM_CH{ar_size}};
    assign m_arburst = {NUM_CH{ar_burst}};

    // beat_cnt holds the remaining DECERR beats after the current one
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_state <= R_IDLE;
            ar_addr  <= '0;
            ar_len   <= '0;
            ar_size  <= '0;
            ar_burst <= '0;
            ar_sel   <= '0;
            beat_cnt <= '0;
        end else begin
            rd_state <= rd_next;
            if (s_arvalid && s_arready) begin
                ar_addr  <= s_araddr[CH_ADDR_WIDTH-1:0];
                ar_len   <= s_arlen;
                ar_size  <= s_arsize;
                ar_burst <= s_arburst;
                ar_sel   <= ar_sel_in;
                beat_cnt <= s_arlen;
            end else if (rd_state == R_ERR && s_rready && beat_cnt != 8'd0) begin
                beat_cnt <= beat_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        rd_next   = rd_state;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rresp   = RESP_OKAY;
        s_rlast   = 1'b0;
        m_arvalid = '0;
        m_rready  = '0;
        if (rstn) begin
            case (rd_state)
                R_IDLE: begin
                    s_arready = 1'b1;
                    if (s_arvalid) rd_next = ar_hit_in ? R_ADDR : R_ERR;
                end
                R_ADDR: begin
                    m_arvalid[ar_sel] = 1'b1;
                    if (m_arready[ar_sel]) rd_next = R_DATA;
                end
                R_DATA: begin
                    s_rvalid          = m_rvalid[ar_sel];
                    s_rdata           = m_rdata[ar_sel*DATA_WIDTH +: DATA_WIDTH];
                    s_rresp           = m_rresp[ar_sel*2 +: 2];
                    s_rlast           = m_rlast[ar_sel];
                    m_rready[ar_sel]  = s_rready;
                    if (s_rvalid && s_rready && s_rlast) rd_next = R_IDLE;
                end
                R_ERR: begin
                    s_rvalid = 1'b1;
                    s_rresp  = RESP_DECERR;
                    s_rlast  = (beat_cnt == 8'd0);
                    if (s_rready && s_rlast) rd_next = R_IDLE;
                end
                default: rd_next = R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hp_axi_router.sv
// AXI4 1-to-N burst router: the channel is chosen by an address field, write
// and read paths run independently with one outstanding burst each.
module hp_axi_router
    import axi_router_pkg::*;
#(
    parameter int ADDR_WIDTH    = 48,
    parameter int CH_ADDR_WIDTH = 34,
    parameter int DATA_WIDTH    = 128,
    parameter int NUM_CH        = 2,
    parameter int SEL_LSB       = 34
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [ADDR_WIDTH-1:0]             s_awaddr,
    input  logic [7:0]                        s_awlen,
    input  logic [2:0]                        s_awsize,
    input  logic [1:0]                        s_awburst,
    input  logic                              s_awvalid,
    output logic                              s_awready,
    input  logic [DATA_WIDTH-1:0]             s_wdata,
    input  logic [DATA_WIDTH/8-1:0]           s_wstrb,
    input  logic                              s_wlast,
    input  logic                              s_wvalid,
    output logic                              s_wready,
    output logic                              s_bvalid,
    output logic [1:0]                        s_bresp,
    input  logic                              s_bready,
    input  logic [ADDR_WIDTH-1:0]             s_araddr,
    input  logic [7:0]                        s_arlen,
    input  logic [2:0]                        s_arsize,
    input  logic [1:0]                        s_arburst,
    input  logic                              s_arvalid,
    output logic                              s_arready,
    output logic                              s_rvalid,
    output logic [DATA_WIDTH-1:0]             s_rdata,
    output logic [1:0]                        s_rresp,
    output logic                              s_rlast,
    input  logic                              s_rready,
    output logic [NUM_CH*CH_ADDR_WIDTH-1:0]   m_awaddr,
    output logic [NUM_CH*8-1:0]               m_awlen,
    output logic [NUM_CH*3-1:0]               m_awsize,
    output logic [NUM_CH*2-1:0]               m_awburst,
    output logic [NUM_CH-1:0]                 m_awvalid,
    input  logic [NUM_CH-1:0]                 m_awready,
    output logic [NUM_CH*DATA_WIDTH-1:0]      m_wdata,
    output logic [NUM_CH*DATA_WIDTH/8-1:0]    m_wstrb,
    output logic [NUM_CH-1:0]                 m_wlast,
    output logic [NUM_CH-1:0]                 m_wvalid,
    input  logic [NUM_CH-1:0]                 m_wready,
    input  logic [NUM_CH-1:0]                 m_bvalid,
    input  logic [NUM_CH*2-1:0]               m_bresp,
    output logic [NUM_CH-1:0]                 m_bready,
    output logic [NUM_CH*CH_ADDR_WIDTH-1:0]   m_araddr,
    output logic [NUM_CH*8-1:0]               m_arlen,
    output logic [NUM_CH*3-1:0]               m_arsize,
    output logic [NUM_CH*2-1:0]               m_arburst,
    output logic [NUM_CH-1:0]                 m_arvalid,
    input  logic [NUM_CH-1:0]                 m_arready,
    input  logic [NUM_CH-1:0]                 m_rvalid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]      m_rdata,
    input  logic [NUM_CH*2-1:0]               m_rresp,
    input  logic [NUM_CH-1:0]                 m_rlast,
    output logic [NUM_CH-1:0]                 m_rready
);

    localparam int              SEL_W    = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam logic [SEL_W:0]  CH_COUNT = (SEL_W+1)'(NUM_CH);

    wr_state_t                  wr_state;
    wr_state_t                  wr_next;
    logic [CH_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                 aw_len;
    logic [2:0]                 aw_size;
    logic [1:0]                 aw_burst;
    logic [SEL_W-1:0]           aw_sel;
    logic                       aw_hit;
    logic [SEL_W-1:0]           aw_sel_in;
    logic                       aw_hit_in;
    logic                       unused_aw_bits;

    assign aw_sel_in      = s_awaddr[SEL_LSB +: SEL_W];
    assign aw_hit_in      = ({1'b0, aw_sel_in} < CH_COUNT);
    assign unused_aw_bits = &{1'b0, s_awaddr};

    // Address, attributes and write beats are broadcast; only valid/ready are steered
    assign m_awaddr  = {NUM_CH{aw_addr}};
    assign m_awlen   = {NUM_CH{aw_len}};
    assign m_awsize  = {NUM_CH{aw_size}};
    assign m_awburst = {NUM_CH{aw_burst}};
    assign m_wdata   = {NUM_CH{s_wdata}};
    assign m_wstrb   = {NUM_CH{s_wstrb}};
    assign m_wlast   = {NUM_CH{s_wlast}};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_state <= W_IDLE;
            aw_addr  <= '0;
            aw_len   <= '0;
            aw_size  <= '0;
            aw_burst <= '0;
            aw_sel   <= '0;
            aw_hit   <= 1'b0;
        end else begin
            wr_state <= wr_next;
            if (s_awvalid && s_awready) begin
                aw_addr  <= s_awaddr[CH_ADDR_WIDTH-1:0];
                aw_len   <= s_awlen;
                aw_size  <= s_awsize;
                aw_burst <= s_awburst;
                aw_sel   <= aw_sel_in;
                aw_hit   <= aw_hit_in;
            end
        end
    end

    // A decode miss skips W_ADDR and sinks the data beats before a DECERR response
    always_comb begin
        wr_next   = wr_state;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_bresp   = RESP_OKAY;
        m_awvalid = '0;
        m_wvalid  = '0;
        m_bready  = '0;
        if (rstn) begin
            case (wr_state)
                W_IDLE: begin
                    s_awready = 1'b1;
                    if (s_awvalid) wr_next = aw_hit_in ? W_ADDR : W_DATA;
                end
                W_ADDR: begin
                    m_awvalid[aw_sel] = 1'b1;
                    if (m_awready[aw_sel]) wr_next = W_DATA;
                end
                W_DATA: begin
                    if (aw_hit) begin
                        m_wvalid[aw_sel] = s_wvalid;
                        s_wready         = m_wready[aw_sel];
                    end else begin
                        s_wready = 1'b1;
                    end
                    if (s_wvalid && s_wready && s_wlast) wr_next = W_RESP;
                end
                W_RESP: begin
                    if (aw_hit) begin
                        s_bvalid         = m_bvalid[aw_sel];
                        s_bresp          = m_bresp[aw_sel*2 +: 2];
                        m_bready[aw_sel] = s_bready;
                    end else begin
                        s_bvalid = 1'b1;
                        s_bresp  = RESP_DECERR;
                    end
                    if (s_bvalid && s_bready) wr_next = W_IDLE;
                end
                default: wr_next = W_IDLE;
            endcase
        end
    end

    hp_axi_router_rd #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .CH_ADDR_WIDTH (CH_ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .NUM_CH        (NUM_CH),
        .SEL_LSB       (SEL_LSB),
        .SEL_W         (SEL_W)
    ) u_rd (
        .clk       (clk),
        .rstn      (rstn),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arburst (s_arburst),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rready  (s_rready),
        .s_rvalid  (s_rvalid),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rready  (m_rready),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast)
    );

endmodule

// File: tb/tb_hp_axi_router.sv
// Directed bench for hp_axi_router: a two-channel instance for routed traffic
// and a three-channel instance whose unused select code exercises decode misses.
module tb_hp_axi_router;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // Two-channel instance
    logic [47:0]  s_awaddr, s_araddr;
    logic [7:0]   s_awlen, s_arlen;
    logic [2:0]   s_awsize, s_arsize;
    logic [1:0]   s_awburst, s_arburst;
    logic         s_awvalid, s_arvalid, s_wvalid, s_wlast, s_bready, s_rready;
    logic         s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast;
    logic [127:0] s_wdata, s_rdata;
    logic [15:0]  s_wstrb;
    logic [1:0]   s_bresp, s_rresp;
    logic [67:0]  m_awaddr, m_araddr;
    logic [15:0]  m_awlen, m_arlen;
    logic [5:0]   m_awsize, m_arsize;
    logic [3:0]   m_awburst, m_arburst;
    logic [255:0] m_wdata, m_rdata;
    logic [31:0]  m_wstrb;
    logic [1:0]   m_awvalid, m_arvalid, m_wvalid, m_wlast, m_bready, m_rready;
    logic [1:0]   m_awready, m_arready, m_wready, m_bvalid, m_rvalid, m_rlast;
    logic [3:0]   m_bresp, m_rresp;

    // Three-channel instance
    logic [47:0]  x_s_awaddr, x_s_araddr;
    logic [7:0]   x_s_awlen, x_s_arlen;
    logic [2:0]   x_s_awsize, x_s_arsize;
    logic [1:0]   x_s_awburst, x_s_arburst;
    logic         x_s_awvalid, x_s_arvalid, x_s_wvalid, x_s_wlast, x_s_bready, x_s_rready;
    logic         x_s_awready, x_s_arready, x_s_wready, x_s_bvalid, x_s_rvalid, x_s_rlast;
    logic [127:0] x_s_wdata, x_s_rdata;
    logic [15:0]  x_s_wstrb;
    logic [1:0]   x_s_bresp, x_s_rresp;
    logic [101:0] x_m_awaddr, x_m_araddr;
    logic [23:0]  x_m_awlen, x_m_arlen;
    logic [8:0]   x_m_awsize, x_m_arsize;
    logic [5:0]   x_m_awburst, x_m_arburst;
    logic [383:0] x_m_wdata, x_m_rdata;
    logic [47:0]  x_m_wstrb;
    logic [2:0]   x_m_awvalid, x_m_arvalid, x_m_wvalid, x_m_wlast, x_m_bready, x_m_rready;
    logic [2:0]   x_m_awready, x_m_arready, x_m_wready, x_m_bvalid, x_m_rvalid, x_m_rlast;
    logic [5:0]   x_m_bresp, x_m_rresp;

    int           vec_count   = 0;
    int           miscompares = 0;
    int           beat;
    logic [127:0] rd_beat;

    hp_axi_router dut2 (
        .clk(clk), .rstn(rstn),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rready(s_rready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rready(m_rready)
    );

    hp_axi_router #(.NUM_CH(3)) dut3 (
        .clk(clk), .rstn(rstn),
        .s_awaddr(x_s_awaddr), .s_awlen(x_s_awlen), .s_awsize(x_s_awsize), .s_awburst(x_s_awburst),
        .s_awvalid(x_s_awvalid), .s_awready(x_s_awready),
        .s_wdata(x_s_wdata), .s_wstrb(x_s_wstrb), .s_wlast(x_s_wlast), .s_wvalid(x_s_wvalid), .s_wready(x_s_wready),
        .s_bvalid(x_s_bvalid), .s_bresp(x_s_bresp), .s_bready(x_s_bready),
        .s_araddr(x_s_araddr), .s_arlen(x_s_arlen), .s_arsize(x_s_arsize), .s_arburst(x_s_arburst),
        .s_arvalid(x_s_arvalid), .s_arready(x_s_arready),
        .s_rvalid(x_s_rvalid), .s_rdata(x_s_rdata), .s_rresp(x_s_rresp), .s_rlast(x_s_rlast), .s_rready(x_s_rready),
        .m_awaddr(x_m_awaddr), .m_awlen(x_m_awlen), .m_awsize(x_m_awsize), .m_awburst(x_m_awburst),
        .m_awvalid(x_m_awvalid), .m_awready(x_m_awready),
        .m_wdata(x_m_wdata), .m_wstrb(x_m_wstrb), .m_wlast(x_m_wlast), .m_wvalid(x_m_wvalid), .m_wready(x_m_wready),
        .m_bvalid(x_m_bvalid), .m_bresp(x_m_bresp), .m_bready(x_m_bready),
        .m_araddr(x_m_araddr), .m_arlen(x_m_arlen), .m_arsize(x_m_arsize), .m_arburst(x_m_arburst),
        .m_arvalid(x_m_arvalid), .m_arready(x_m_arready),
        .m_rvalid(x_m_rvalid), .m_rdata(x_m_rdata), .m_rresp(x_m_rresp), .m_rlast(x_m_rlast), .m_rready(x_m_rready)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven from here
    task automatic applyStimulus();
        @(posedge clk);
        #2;
    endtask

    task automatic clearInputs();
        s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 0;
        s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = 0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 0; s_wvalid = 0; s_bready = 0; s_rready = 0;
        m_awready = '0; m_arready = '0; m_wready = '0; m_bvalid = '0; m_bresp = '0;
        m_rvalid = '0; m_rdata = '0; m_rresp = '0; m_rlast = '0;
        x_s_awaddr = '0; x_s_awlen = '0; x_s_awsize = '0; x_s_awburst = '0; x_s_awvalid = 0;
        x_s_araddr = '0; x_s_arlen = '0; x_s_arsize = '0; x_s_arburst = '0; x_s_arvalid = 0;
        x_s_wdata = '0; x_s_wstrb = '0; x_s_wlast = 0; x_s_wvalid = 0; x_s_bready = 0; x_s_rready = 0;
        x_m_awready = '1; x_m_arready = '1; x_m_wready = '1; x_m_bvalid = '1; x_m_bresp = '0;
        x_m_rvalid = '1; x_m_rdata = '1; x_m_rresp = '0; x_m_rlast = '0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearInputs();
        rstn = 1'b0;
        repeat (2) applyStimulus();
        #1;
        checkOutput("rst_awready", 128'(s_awready), 128'(0));
        checkOutput("rst_arready", 128'(s_arready), 128'(0));
        rstn = 1'b1;
        #1;
        checkOutput("idle_awready", 128'(s_awready), 128'(1));
        checkOutput("idle_arready", 128'(s_arready), 128'(1));
        checkOutput("idle_valids", 128'({m_awvalid, m_arvalid, m_wvalid, s_bvalid, s_rvalid}), 128'(0));
        checkOutput("idle_resp_data", 128'({s_bresp, s_rresp, s_rdata}), 128'(0));

        // Routed write to channel 1, four beats
        s_awaddr = 48'h4_0000_1000; s_awlen = 8'd3; s_awsize = 3'd4; s_awburst = 2'b01; s_awvalid = 1;
        #1;
        checkOutput("t1_aw_hs", 128'(s_awready), 128'(1));
        checkOutput("t1_awvalid_early", 128'(m_awvalid), 128'(0));
        applyStimulus();
        s_awvalid = 0; s_wvalid = 1; s_wdata = 128'h1; m_wready = 2'b11;
        #1;
        checkOutput("t1_awvalid", 128'(m_awvalid), 128'(2'b10));
        checkOutput("t1_awaddr_ch1", 128'(m_awaddr[34 +: 34]), 128'(34'h1000));
        checkOutput("t1_awlen_ch1", 128'(m_awlen[15:8]), 128'(3));
        checkOutput("t1_early_w_wait", 128'({s_wready, m_wvalid}), 128'(0));
        applyStimulus();
        m_awready = 2'b10;
        #1;
        checkOutput("t1_awvalid_hold", 128'(m_awvalid), 128'(2'b10));
        applyStimulus();
        m_awready = 2'b00;
        for (int i = 0; i < 4; i++) begin
            s_wdata = {4{32'hA5A5_0000 + 32'(i)}}; s_wstrb = 16'hFFFF; s_wlast = (i == 3);
            s_wvalid = 1; m_wready = 2'b10;
            #1;
            checkOutput("t1_wvalid", 128'(m_wvalid), 128'(2'b10));
            checkOutput("t1_wready", 128'(s_wready), 128'(1));
            checkOutput("t1_wdata_ch1", m_wdata[128 +: 128], {4{32'hA5A5_0000 + 32'(i)}});
            checkOutput("t1_wlast_ch1", 128'(m_wlast[1]), 128'(i == 3));
            applyStimulus();
        end
        s_wvalid = 0; s_wlast = 0; m_wready = 2'b00; s_bready = 1;
        #1;
        checkOutput("t1_bvalid_wait", 128'(s_bvalid), 128'(0));
        checkOutput("t1_bready", 128'(m_bready), 128'(2'b10));
        applyStimulus();
        m_bvalid = 2'b11; m_bresp = 4'b10_01;
        #1;
        checkOutput("t1_bvalid", 128'(s_bvalid), 128'(1));
        checkOutput("t1_bresp", 128'(s_bresp), 128'(2'b10));
        applyStimulus();
        m_bvalid = 2'b00; m_bresp = 4'b0; s_bready = 0;
        #1;
        checkOutput("t1_back_idle", 128'({s_awready, s_bvalid}), 128'(2'b10));

        // Routed read from channel 0, eight beats with a toggling rready
        s_araddr = 48'h0_0000_0040; s_arlen = 8'd7; s_arvalid = 1;
        #1;
        checkOutput("t2_ar_hs", 128'(s_arready), 128'(1));
        applyStimulus();
        s_arvalid = 0; m_arready = 2'b01;
        #1;
        checkOutput("t2_arvalid", 128'(m_arvalid), 128'(2'b01));
        checkOutput("t2_araddr_ch0", 128'(m_araddr[0 +: 34]), 128'(34'h40));
        checkOutput("t2_arlen_ch0", 128'(m_arlen[7:0]), 128'(7));
        applyStimulus();
        m_arready = 2'b00;
        beat = 0;
        for (int cyc = 0; cyc < 32 && beat < 8; cyc++) begin
            rd_beat  = {4{32'hC0DE_0000 + 32'(beat)}};
            m_rvalid = 2'b11; m_rdata = {128'hDEAD_BEEF, rd_beat};
            m_rlast  = {1'b1, beat == 7}; m_rresp = 4'b11_00;
            s_rready = (cyc % 2 == 0);
            #1;
            checkOutput("t2_rvalid", 128'(s_rvalid), 128'(1));
            checkOutput("t2_rdata", s_rdata, rd_beat);
            checkOutput("t2_rlast", 128'(s_rlast), 128'(beat == 7));
            checkOutput("t2_rready", 128'(m_rready), 128'({1'b0, s_rready}));
            if (s_rready) beat++;
            applyStimulus();
        end
        checkOutput("t2_beat_count", 128'(beat), 128'(8));
        m_rvalid = 2'b00; m_rlast = 2'b00; s_rready = 0;
        #1;
        checkOutput("t2_back_idle", 128'({s_arready, s_rvalid}), 128'(2'b10));

        // Simultaneous AW to channel 0 and AR to channel 1; AW stalls on awready
        s_awaddr = 48'h0_0000_2000; s_awlen = 8'd0; s_awvalid = 1;
        s_araddr = 48'h4_0000_0080; s_arlen = 8'd1; s_arvalid = 1;
        #1;
        checkOutput("t5_both_ready", 128'({s_awready, s_arready}), 128'(2'b11));
        applyStimulus();
        s_awvalid = 0; s_arvalid = 0; m_arready = 2'b10;
        #1;
        checkOutput("t5_awvalid", 128'(m_awvalid), 128'(2'b01));
        checkOutput("t5_arvalid", 128'(m_arvalid), 128'(2'b10));
        checkOutput("t5_araddr_ch1", 128'(m_araddr[34 +: 34]), 128'(34'h80));
        applyStimulus();
        m_arready = 2'b00;
        for (int b = 0; b < 2; b++) begin
            rd_beat  = {4{32'h5EED_0000 + 32'(b)}};
            m_rvalid = 2'b10; m_rdata = {rd_beat, 128'hBAD0}; m_rlast = (b == 1) ? 2'b10 : 2'b00;
            s_rready = 1;
            #1;
            checkOutput("t5_rdata", s_rdata, rd_beat);
            checkOutput("t5_rlast", 128'(s_rlast), 128'(b == 1));
            applyStimulus();
        end
        m_rvalid = 2'b00; m_rlast = 2'b00; s_rready = 0;
        #1;
        checkOutput("t5_rd_done", 128'(s_arready), 128'(1));
        checkOutput("t5_aw_still_waiting", 128'(m_awvalid), 128'(2'b01));
        applyStimulus();
        applyStimulus();
        m_awready = 2'b01;
        #1;
        checkOutput("t5_awvalid_late", 128'(m_awvalid), 128'(2'b01));
        applyStimulus();
        m_awready = 2'b00; s_wvalid = 1; s_wlast = 1; m_wready = 2'b01;
        #1;
        checkOutput("t5_wvalid", 128'(m_wvalid), 128'(2'b01));
        checkOutput("t5_wready", 128'(s_wready), 128'(1));
        applyStimulus();
        s_wvalid = 0; s_wlast = 0; m_wready = 2'b00; m_bvalid = 2'b01; m_bresp = 4'b00_00; s_bready = 1;
        #1;
        checkOutput("t5_bvalid", 128'({s_bvalid, s_bresp}), 128'(3'b100));
        applyStimulus();
        m_bvalid = 2'b00; s_bready = 0;

        // Reset during the second write beat abandons the burst
        s_awaddr = 48'h0_0000_3000; s_awlen = 8'd3; s_awvalid = 1;
        applyStimulus();
        s_awvalid = 0; m_awready = 2'b01;
        applyStimulus();
        m_awready = 2'b00; s_wvalid = 1; s_wlast = 0; m_wready = 2'b01;
        #1;
        checkOutput("t6_beat1_ready", 128'(s_wready), 128'(1));
        applyStimulus();
        rstn = 0;
        applyStimulus();
        #1;
        checkOutput("t6_rst_valids", 128'({m_wvalid, s_wready, m_awvalid, s_bvalid, s_rvalid, s_awready}), 128'(0));
        rstn = 1;
        #1;
        checkOutput("t6_awready_after", 128'(s_awready), 128'(1));
        checkOutput("t6_w_blocked", 128'({s_wready, m_wvalid}), 128'(0));
        s_wvalid = 0; m_wready = 2'b00; s_bready = 1;
        applyStimulus();
        #1;
        checkOutput("t6_no_bresp", 128'(s_bvalid), 128'(0));
        s_bready = 0;

        // Three-channel instance: read decode miss, arlen=2
        x_s_araddr = 48'hC_0000_0000; x_s_arlen = 8'd2; x_s_arvalid = 1;
        #1;
        checkOutput("t3_ar_hs", 128'(x_s_arready), 128'(1));
        applyStimulus();
        x_s_arvalid = 0; x_s_rready = 0;
        #1;
        checkOutput("t3_stall_rlast", 128'({x_s_rvalid, x_s_rlast}), 128'(2'b10));
        applyStimulus();
        x_s_rready = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("t3_rvalid", 128'(x_s_rvalid), 128'(1));
            checkOutput("t3_rdata", x_s_rdata, 128'(0));
            checkOutput("t3_rresp", 128'(x_s_rresp), 128'(2'b11));
            checkOutput("t3_rlast", 128'(x_s_rlast), 128'(k == 2));
            checkOutput("t3_no_master", 128'({x_m_arvalid, x_m_rready}), 128'(0));
            applyStimulus();
        end
        #1;
        checkOutput("t3_done", 128'({x_s_arready, x_s_rvalid}), 128'(2'b10));

        // Read miss with arlen=0 gives one beat
        x_s_arlen = 8'd0; x_s_arvalid = 1;
        applyStimulus();
        x_s_arvalid = 0;
        #1;
        checkOutput("t3b_single_rlast", 128'({x_s_rvalid, x_s_rlast}), 128'(2'b11));
        applyStimulus();
        #1;
        checkOutput("t3b_done", 128'(x_s_rvalid), 128'(0));

        // Read miss with arlen=255 gives 256 beats
        x_s_arlen = 8'd255; x_s_arvalid = 1;
        applyStimulus();
        x_s_arvalid = 0;
        beat = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            #1;
            if (!x_s_rvalid) break;
            beat++;
            if (x_s_rlast) begin
                applyStimulus();
                break;
            end
            applyStimulus();
        end
        checkOutput("t3c_beat_count", 128'(beat), 128'(256));
        x_s_rready = 0;

        // Three-channel instance: write decode miss, awlen=0
        x_s_awaddr = 48'hC_0000_0000; x_s_awlen = 8'd0; x_s_awvalid = 1;
        #1;
        checkOutput("t4_aw_hs", 128'(x_s_awready), 128'(1));
        applyStimulus();
        x_s_awvalid = 0; x_s_wvalid = 1; x_s_wlast = 1;
        #1;
        checkOutput("t4_no_awvalid", 128'(x_m_awvalid), 128'(0));
        checkOutput("t4_sink_ready", 128'(x_s_wready), 128'(1));
        checkOutput("t4_no_wvalid", 128'(x_m_wvalid), 128'(0));
        applyStimulus();
        x_s_wvalid = 0; x_s_wlast = 0; x_s_bready = 0;
        #1;
        checkOutput("t4_bvalid", 128'(x_s_bvalid), 128'(1));
        checkOutput("t4_bresp", 128'(x_s_bresp), 128'(2'b11));
        checkOutput("t4_no_bready", 128'(x_m_bready), 128'(0));
        applyStimulus();
        x_s_bready = 1;
        #1;
        checkOutput("t4_bvalid_hold", 128'(x_s_bvalid), 128'(1));
        applyStimulus();
        x_s_bready = 0;
        #1;
        checkOutput("t4_done", 128'({x_s_awready, x_s_bvalid}), 128'(2'b10));

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/hp_axi_router.md
Name: hp_axi_router

Overview:
- AXI4 1-to-N burst router. Takes the HP slave port of the NVMe driver datapath and fans it out to NUM_CH memory master channels.
- Generalises the fixed main/sub pair to a parametrised channel count.
- Channel select is a field of the burst address.
- Independent write and read paths, one outstanding burst per direction.
- Decode misses get an internal DECERR response.

Parameters:
ADDR_WIDTH, 48, slave address width
CH_ADDR_WIDTH, 34, master address width; forwarded address = s_addr[CH_ADDR_WIDTH-1:0]
DATA_WIDTH, 128, data width, both sides
NUM_CH, 2, master channel count, 1..8
SEL_LSB, 34, LSB of channel-select field; field width SEL_W = max(1, clog2(NUM_CH))

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
s_awaddr/s_araddr  in  ADDR_WIDTH  slave burst address
s_awlen/s_arlen, s_awsize/s_arsize, s_awburst/s_arburst  in  8/3/2  burst attributes
s_awvalid, s_arvalid, s_wvalid, s_wlast, s_bready, s_rready  in  1  slave handshakes
s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast  out  1  slave handshakes
s_wdata/s_wstrb  in  DATA_WIDTH/DATA_WIDTH/8  write beat
s_rdata  out  DATA_WIDTH  read data; s_bresp/s_rresp  out  2  responses
m_awaddr/m_araddr  out  NUM_CH*CH_ADDR_WIDTH  flattened; channel i at [i*CH_ADDR_WIDTH +: CH_ADDR_WIDTH]
m_awlen/m_arlen, m_awsize/m_arsize, m_awburst/m_arburst  out  NUM_CH*8/*3/*2  burst attributes
m_wdata/m_wstrb  out  NUM_CH*DATA_WIDTH/NUM_CH*DATA_WIDTH/8  write beat
m_awvalid, m_arvalid, m_wvalid, m_wlast, m_bready, m_rready  out  NUM_CH  per-channel handshakes
m_awready, m_arready, m_wready, m_bvalid, m_rvalid, m_rlast  in  NUM_CH  per-channel handshakes
m_bresp/m_rresp  in  NUM_CH*2; m_rdata  in  NUM_CH*DATA_WIDTH

Behaviour:
- Reset:
  - All valid/ready outputs 0.
  - s_bresp, s_rresp, s_rdata are 0.
  - Both FSMs go to IDLE.
  - Reset mid-burst abandons the burst. No completion is generated.
- Decode: sel = addr[SEL_LSB +: SEL_W]. sel >= NUM_CH is a miss.
- Write FSM:
  - W_IDLE: s_awready=1. On AW handshake, latch addr/len/size/burst/sel. Hit -> W_ADDR, miss -> W_DATA.
  - W_ADDR: m_awvalid[sel]=1 with latched fields, first asserted 1 cycle after the s_aw handshake. Held until m_awready[sel] -> W_DATA.
  - W_DATA (hit): combinational passthrough.
    - m_wvalid[sel]=s_wvalid, s_wready=m_wready[sel].
    - wdata/wstrb/wlast broadcast to all channels.
    - Handshake with s_wlast=1 -> W_RESP.
  - W_DATA (miss): s_wready=1, beats discarded. s_wlast handshake -> W_RESP.
  - W_RESP (hit): s_bvalid=m_bvalid[sel], s_bresp=m_bresp[sel], m_bready[sel]=s_bready.
  - W_RESP (miss): s_bvalid=1, s_bresp=2'b11.
  - B handshake -> W_IDLE.
  - s_wready=0 in W_IDLE/W_ADDR; early W beats wait.
- Read FSM:
  - R_IDLE: s_arready=1. Latch attributes. Hit -> R_ADDR, miss -> R_ERR (load beat counter = arlen).
  - R_ADDR: m_arvalid[sel] held until m_arready[sel] -> R_DATA.
  - R_DATA: passthrough of rvalid/rdata/rresp/rlast from channel sel; m_rready[sel]=s_rready. Handshake with rlast -> R_IDLE.
  - R_ERR: s_rvalid=1, s_rdata=0, s_rresp=2'b11, s_rlast=(cnt==0). Counter decrements per handshake. Last beat -> R_IDLE. arlen=0 gives exactly 1 beat; arlen=255 gives 256 beats.
- Non-selected channels: all valid/ready outputs 0. Address/data fields may carry the broadcast values.
- Write and read paths are fully independent.
  - Simultaneous AW+AR are both accepted the same cycle.
  - The same or different channels may be targeted concurrently.
- NUM_CH=1: SEL_W=1; sel=1 decodes as a miss.
- Slave-side outputs never depend on m_* of non-selected channels.

Decomposition:
- Package axi_router_pkg:
  - RESP_OKAY=2'b00, RESP_DECERR=2'b11.
  - Write-state encoding W_IDLE/W_ADDR/W_DATA/W_RESP.
  - Read-state encoding R_IDLE/R_ADDR/R_DATA/R_ERR.
  - clog2 function.
- One sub-module, hp_axi_router_rd: the read FSM including the DECERR beat generator. Instantiated once. The write path stays in the top module.

Test Plan:
- NUM_CH=2, AW addr=0x4_0000_1000 (sel=1), awlen=3, 4 W beats -> m_awvalid=2'b10, m_awaddr ch1=0x1000; 4 beats on ch1 with wlast on beat 4; s_bresp=m_bresp[1].
- AR addr=0x0_0000_0040 (sel=0), arlen=7, ch0 returns 8 beats with rready toggling -> 8 beats out in order, s_rlast only on beat 8, no m_rready[1] asserted.
- NUM_CH=3, AR with sel=3, arlen=2 -> 3 beats rdata=0, rresp=2'b11, rlast on 3rd; no m_arvalid.
- Decode-miss write, awlen=0 -> 1 beat sunk, s_bvalid with bresp=2'b11; m_wvalid stays 0.
- Same-cycle AW(sel=0) and AR(sel=1) with m_awready held low 5 cycles -> read completes independently; write resumes after m_awready.
- rstn=0 during W_DATA beat 2 -> next cycle all valids 0, s_awready=1 after release.
